// File: rtl/dmem_display_arbiter.sv
// Shares the dmem port between the processor M stage and a per-frame snapshot burst for VGA.
// Define DMEM_ARB_DOUBLE_BUF_EN to double-buffer the snapshot so the VGA side only sees whole frames.
module dmem_display_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'd1000,
  parameter int          BURST_LEN = 8,
  parameter int          IDX_W     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             screen_end,
  input  logic             proc_req,
  input  logic [31:0]      proc_addr,
  input  logic [31:0]      proc_data,
  input  logic             proc_wren,
  output logic [31:0]      proc_q,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data,
  output logic             mem_wren,
  input  logic [31:0]      mem_q,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_word,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun,
  input  logic             clr_overrun
);

  // state | meaning
  // IDLE  | waiting for the start of vertical blank
  // FETCH | issuing/capturing snapshot reads in processor-idle cycles
  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [IDX_W:0] LEN    = (IDX_W+1)'(BURST_LEN);
  localparam logic [IDX_W:0] LEN_M1 = (IDX_W+1)'(BURST_LEN - 1);

  state_t           state, next_state;
  logic             se_prev;
  logic [IDX_W:0]   issue_cnt, recv_cnt;
  logic             pend;
  logic [IDX_W-1:0] pend_idx;
  logic             trig, issue, done_cap;

  assign trig     = screen_end & ~se_prev;
  assign issue    = (state == FETCH) && !proc_req && (issue_cnt < LEN);
  assign done_cap = (state == FETCH) && pend && (recv_cnt == LEN_M1);
  assign busy     = (state == FETCH);
  assign proc_q   = mem_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (trig) next_state = FETCH;
      FETCH:   if (done_cap) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Processor always wins the port; the burst only fills its idle cycles.
  always_comb begin
    mem_addr = 32'd0;
    mem_data = 32'd0;
    mem_wren = 1'b0;
    if (proc_req) begin
      mem_addr = proc_addr;
      mem_data = proc_data;
      mem_wren = proc_wren;
    end else if (issue) begin
      mem_addr = BASE_ADDR + 32'(issue_cnt);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      se_prev    <= 1'b0;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      pend       <= 1'b0;
      pend_idx   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      se_prev    <= screen_end;
      pend       <= issue;
      pend_idx   <= issue_cnt[IDX_W-1:0];
      frame_done <= done_cap;
      if (state == IDLE) begin
        if (trig) begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
        end
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (pend)  recv_cnt  <= recv_cnt + 1'b1;
      end
      if (trig && state == FETCH) overrun <= 1'b1;
      else if (clr_overrun)       overrun <= 1'b0;
    end
  end

`ifdef DMEM_ARB_DOUBLE_BUF_EN
  logic [31:0] snap [2][BURST_LEN];
  logic        front;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      front <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < BURST_LEN; i++)
          snap[b][i] <= 32'd0;
    end else begin
      if (state == FETCH && pend) snap[~front][pend_idx] <= mem_q;
      if (done_cap) front <= ~front;
    end
  end

  assign rd_word = snap[front][rd_idx];
`else
  logic [31:0] snap [BURST_LEN];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BURST_LEN; i++) snap[i] <= 32'd0;
    end else if (state == FETCH && pend) begin
      snap[pend_idx] <= mem_q;
    end
  end

  assign rd_word = snap[rd_idx];
`endif

endmodule

// File: tb/tb_dmem_display_arbiter.sv
// Directed bench for dmem_display_arbiter with a behavioural synchronous dmem and a snapshot scoreboard.
module tb_dmem_display_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        screen_end = 1'b0;
  logic        proc_req = 1'b0;
  logic [31:0] proc_addr = 32'd0;
  logic [31:0] proc_data = 32'd0;
  logic        proc_wren = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [2:0]  rd_idx = 3'd0;
  logic [31:0] proc_q, mem_addr, mem_data, rd_word, mem_q;
  logic        mem_wren, busy, frame_done, overrun;

  logic [31:0] mem [2048];
  logic        pl_go = 1'b0;
  logic [31:0] pl_base = 32'd0;
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;

  dmem_display_arbiter #(.BASE_ADDR(32'd1000), .BURST_LEN(8), .IDX_W(3)) dut (
    .clock(clock), .reset(reset), .screen_end(screen_end),
    .proc_req(proc_req), .proc_addr(proc_addr), .proc_data(proc_data), .proc_wren(proc_wren),
    .proc_q(proc_q), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .rd_idx(rd_idx), .rd_word(rd_word), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clock = ~clock;

  // Synchronous-read dmem; reset clears it and seeds mem[4] for the proc-read test.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h77;
    end else begin
      if (pl_go)
        for (int i = 0; i < 8; i++) mem[1000+i] <= pl_base + 32'(i);
      if (mem_wren) mem[11'(mem_addr)] <= mem_data;
    end
    mem_q <= mem[11'(mem_addr)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edge_cnt++;
  endtask

  task automatic preload(input logic [31:0] base);
    pl_base = base;
    pl_go = 1'b1;
    tick();
    pl_go = 1'b0;
  endtask

  task automatic trigger_start();
    for (int i = 0; i < 8; i++) exp_q.push_back(pl_base + 32'(i));
    screen_end = 1'b1;
    edge_cnt = 0;
    tick();
    screen_end = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_edges);
    while (frame_done !== 1'b1 && edge_cnt < 200) tick();
    chk({tag, "_latency"}, 32'(edge_cnt), 32'(exp_edges));
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    tick();
    chk({tag, "_done_one_cycle"}, {31'd0, frame_done}, 32'd0);
  endtask

  task automatic check_snapshot(input string tag);
    chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      if (exp_q.size() > 0) chk({tag, "_word"}, rd_word, exp_q.pop_front());
    end
    rd_idx = 3'd0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      chk("rst_word", rd_word, 32'd0);
    end
    rd_idx = 3'd0;
    #1 reset = 1'b1;
    tick();

    // Basic burst, no processor traffic
    preload(32'hA0);
    trigger_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_addr", mem_addr, 32'd1000 + 32'(i));
      chk("t1_wren", {31'd0, mem_wren}, 32'd0);
      tick();
    end
    chk("t1_addr_after_issue", mem_addr, 32'd0);
    wait_done("t1", 10);
    rd_idx = 3'd5;
    #1 chk("t1_idx5", rd_word, 32'hA5);
    check_snapshot("t1");

    // Processor store mid-burst
    preload(32'hC0);
    trigger_start();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      proc_req = 1'b1; proc_addr = 32'd20; proc_wren = 1'b1; proc_data = 32'h55;
      #1;
      chk("t2_proc_addr", mem_addr, 32'd20);
      chk("t2_proc_wren", {31'd0, mem_wren}, 32'd1);
      chk("t2_proc_data", mem_data, 32'h55);
      tick();
    end
    proc_req = 1'b0; proc_wren = 1'b0; proc_data = 32'd0; proc_addr = 32'd0;
    wait_done("t2", 13);
    chk("t2_mem20", mem[20], 32'h55);
    check_snapshot("t2");

    // Interleaved processor reads
    preload(32'hD0);
    trigger_start();
    for (int i = 0; i < 8; i++) begin
      proc_req = 1'b1; proc_addr = 32'd4; proc_wren = 1'b0;
      tick();
      proc_req = 1'b0;
      #1 chk("t3_proc_q", proc_q, 32'h77);
      tick();
    end
    proc_addr = 32'd0;
    wait_done("t3", 18);
    check_snapshot("t3");

    // Overrun: second rising edge mid-burst, coinciding with a clear (set wins)
    preload(32'h30);
    trigger_start();
    tick(); tick(); tick();
    screen_end = 1'b1;
    clr_overrun = 1'b1;
    tick();
    screen_end = 1'b0;
    clr_overrun = 1'b0;
    chk("t4_overrun_set", {31'd0, overrun}, 32'd1);
    wait_done("t4", 10);
    for (int i = 0; i < 5; i++) begin
      chk("t4_no_extra_done", {31'd0, frame_done}, 32'd0);
      tick();
    end
    chk("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
    check_snapshot("t4");
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("t4_overrun_clr", {31'd0, overrun}, 32'd0);

    // Async reset after three captures
    preload(32'h60);
    trigger_start();
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_frame_done", {31'd0, frame_done}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1 chk("t5_word_cleared", rd_word, 32'd0);
    end
    rd_idx = 3'd0;
    #1 reset = 1'b1;
    tick();
    preload(32'hE0);
    trigger_start();
    wait_done("t5_after", 10);
    check_snapshot("t5_after");

`ifdef DMEM_ARB_DOUBLE_BUF_EN
    // Front bank holds the previous frame until the swap
    preload(32'hA0);
    trigger_start();
    wait_done("t6_f1", 10);
    check_snapshot("t6_f1");
    preload(32'hB0);
    rd_idx = 3'd0;
    trigger_start();
    while (frame_done !== 1'b1 && edge_cnt < 200) begin
      chk("t6_front_stable", rd_word, 32'hA0);
      tick();
    end
    chk("t6_latency", 32'(edge_cnt), 32'd10);
    chk("t6_swap_at_done", rd_word, 32'hB0);
    check_snapshot("t6_f2");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_display_arbiter.md
Name: dmem_display_arbiter

Overview:
- Shares the single data-memory port between the pipelined processor's memory stage and the display path.
- On each rising edge of screen_end (start of vertical blank), it fetches a burst of game-state words from dmem into a local snapshot buffer. The VGA logic reads that buffer combinationally.
- The processor always has priority. The arbiter uses only cycles where the processor makes no dmem access, so the pipeline never stalls for display traffic.

Parameters:
- BASE_ADDR, 32'd1000, dmem word address of snapshot word 0.
- BURST_LEN, 8, number of words fetched per frame (2..256).
- IDX_W, 3, index width; equals clog2(BURST_LEN).

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low: asserted at 0, released at 1.
- screen_end  in  1  level from VGA timing; high during vertical blank.
- proc_req  in  1  processor M stage holds lw or sw this cycle.
- proc_addr  in  32  processor dmem address.
- proc_data  in  32  processor store data.
- proc_wren  in  1  processor store enable (only meaningful with proc_req).
- proc_q  out  32  read data to processor; combinational copy of mem_q.
- mem_addr  out  32  address to dmem.
- mem_data  out  32  write data to dmem.
- mem_wren  out  1  write enable to dmem.
- mem_q  in  32  dmem read data, valid one cycle after the address is presented (synchronous RAM).
- rd_idx  in  IDX_W  VGA-side snapshot index.
- rd_word  out  32  snapshot word at rd_idx (combinational).
- busy  out  1  a burst is in progress.
- frame_done  out  1  one-cycle pulse when the last word is captured.
- overrun  out  1  sticky: a new trigger arrived while busy.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; issue_cnt=0, recv_cnt=0, pend=0, se_prev=0.
  - busy=0, frame_done=0, overrun=0.
  - All snapshot words=0.
- Trigger: trig = screen_end & ~se_prev; se_prev registers screen_end every cycle.
- Port mux (combinational):
  - proc_req=1: mem_addr=proc_addr, mem_data=proc_data, mem_wren=proc_wren.
  - Otherwise, in FETCH with issue_cnt<BURST_LEN: mem_addr=BASE_ADDR+issue_cnt, mem_wren=0, mem_data=0.
  - Otherwise: mem_addr=0, mem_wren=0, mem_data=0.
  - Arbiter never drives mem_wren=1.
- States IDLE, FETCH:
  - IDLE: on trig, go to FETCH; issue_cnt=0, recv_cnt=0; busy=1 from the next cycle.
  - FETCH, issue: a cycle with proc_req=0 and issue_cnt<BURST_LEN issues a read. At the edge, issue_cnt++, pend=1, pend_idx=issue_cnt. Otherwise pend=0.
  - FETCH, capture: at an edge with pend=1, snapshot[pend_idx]=mem_q and recv_cnt++. Capture ignores proc_req, because the read was issued the previous cycle.
  - FETCH, completion: when a capture makes recv_cnt reach BURST_LEN, go to IDLE. frame_done=1 for exactly the following cycle; busy=0 in that same cycle.
- Latency with proc_req held 0: trig sampled at edge k → issues after edges k..k+BURST_LEN-1 → frame_done high in the cycle after edge k+BURST_LEN+1.
- Each cycle with proc_req=1 during FETCH delays completion by one cycle.
- If proc_req stays high, the burst stalls indefinitely. No timeout.
- trig while in FETCH: ignored (the burst continues), overrun set to 1.
- clr_overrun and a new overrun in the same cycle: set wins.
- Processor store to an address already fetched this burst: not reflected until the next frame.
- A read captured in the same cycle as a trigger completes normally.
- proc_q = mem_q at all times. The processor ignores it on cycles it did not issue a read.

Optional Feature:
- Macro DMEM_ARB_DOUBLE_BUF_EN.
- Defined:
  - Two snapshot banks. The burst writes the back bank; rd_word reads the front bank.
  - Banks swap at the completion edge, together with the frame_done assertion.
  - The VGA side never sees a partially updated frame.
  - Reset clears both banks; front bank is bank 0.
- Undefined:
  - Single bank, updated in place as words arrive.
  - rd_word may mix old and new words while busy=1.

Test Plan:
- Reset, then trigger, no proc traffic: dmem preloaded with mem[1000+i]=0xA0+i. Pulse screen_end → mem_addr steps 1000..1007 on consecutive cycles, frame_done after 10 cycles, rd_idx=5 gives 0xA5.
- Processor priority: trigger, then proc_req=1, proc_addr=20, proc_wren=1, proc_data=0x55 for 3 cycles mid-burst → mem_addr=20 and mem_wren=1 in those cycles, mem[20]=0x55, frame_done delayed exactly 3 cycles, all 8 snapshot words correct.
- Interleaved read: proc_req alternating 1/0 with proc_addr=4 (mem[4]=0x77) → proc_q=0x77 the cycle after each proc read, burst completes in 8 idle cycles, no misplaced captures.
- Overrun: second screen_end rising edge 4 cycles after the first → overrun=1, burst still completes with one frame_done. clr_overrun=1 for 1 cycle → overrun=0.
- Async reset mid-burst: drive reset=0 after 3 captures → busy=0, rd_word=0 for all indices without waiting for a clock. A new trigger after release does a full 8-word burst.
- DMEM_ARB_DOUBLE_BUF_EN: frame 1 loads 0xA0.., frame 2 loads 0xB0.. → rd_idx=0 reads 0xA0 throughout frame 2's burst, then 0xB0 starting the frame_done cycle.
